// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus, waits for a stable pattern, and decodes it back to hex per digit.
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DECODER_DP_EN.
module seg7_scan_decoder #(
    parameter int NDIG       = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic [6:0]        seg_in,
`ifdef SEG7_SCAN_DECODER_DP_EN
    input  logic              dp_in,
    output logic [NDIG-1:0]   dig_dp,
`endif
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_valid,
    output logic [NDIG-1:0]   dig_err,
    output logic              upd_stb,
    output logic [2:0]        upd_idx
);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

    localparam logic [1:0] KIND_VALUE   = 2'd0;
    localparam logic [1:0] KIND_BLANK   = 2'd1;
    localparam logic [1:0] KIND_UNKNOWN = 2'd2;

    state_t          state_reg;
    logic [NDIG-1:0] sel_reg;
    logic [6:0]      seg_reg;
    logic            dp_reg;
    logic [3:0]      cnt_reg;
    logic            commit_pending_reg;

    logic [3:0]      digit_reg [NDIG];
    logic [NDIG-1:0] valid_reg;
    logic [NDIG-1:0] err_reg;
    logic [NDIG-1:0] dp_out_reg;
    logic            upd_stb_reg;
    logic [2:0]      upd_idx_reg;

    logic            cur_dp;
    logic            sel_good;
    logic            same_sample;
    logic [2:0]      sel_idx;
    logic [3:0]      dec_val;
    logic [1:0]      dec_kind;

`ifdef SEG7_SCAN_DECODER_DP_EN
    assign cur_dp = dp_in;
    assign dig_dp = dp_out_reg;
`else
    assign cur_dp = 1'b1;
`endif

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign sel_good    = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    assign same_sample = (dig_sel == sel_reg) && (seg_in == seg_reg) && (cur_dp == dp_reg);

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_reg[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        dec_val  = 4'h0;
        dec_kind = KIND_VALUE;
        case (seg_reg)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0011000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            7'b1111111: dec_kind = KIND_BLANK;
            default:    dec_kind = KIND_UNKNOWN;
        endcase
    end

    // Stability tracker; commit_pending is a one-cycle flag consumed by the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            sel_reg            <= '0;
            seg_reg            <= '0;
            dp_reg             <= 1'b0;
            cnt_reg            <= 4'd0;
            commit_pending_reg <= 1'b0;
        end else begin
            commit_pending_reg <= 1'b0;
            if (sample_en) begin
                if (!sel_good) begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                end else if (state_reg == IDLE || !same_sample) begin
                    sel_reg   <= dig_sel;
                    seg_reg   <= seg_in;
                    dp_reg    <= cur_dp;
                    cnt_reg   <= 4'd1;
                    state_reg <= TRACK;
                end else if (state_reg == TRACK) begin
                    if (cnt_reg + 4'd1 >= STABLE_MAX) begin
                        cnt_reg            <= STABLE_MAX;
                        commit_pending_reg <= 1'b1;
                        state_reg          <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                digit_reg[i] <= 4'h0;
            end
            valid_reg   <= '0;
            err_reg     <= '0;
            dp_out_reg  <= '0;
            upd_stb_reg <= 1'b0;
            upd_idx_reg <= 3'd0;
        end else begin
            upd_stb_reg <= commit_pending_reg;
            if (commit_pending_reg) begin
                upd_idx_reg <= sel_idx;
                for (int i = 0; i < NDIG; i++) begin
                    if (sel_reg[i]) begin
                        dp_out_reg[i] <= ~dp_reg;
                        case (dec_kind)
                            KIND_VALUE: begin
                                digit_reg[i] <= dec_val;
                                valid_reg[i] <= 1'b1;
                                err_reg[i]   <= 1'b0;
                            end
                            KIND_BLANK: begin
                                digit_reg[i] <= 4'h0;
                                valid_reg[i] <= 1'b0;
                                err_reg[i]   <= 1'b0;
                            end
                            default: begin
                                valid_reg[i] <= 1'b0;
                                err_reg[i]   <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_pack
            assign digits[4*gi +: 4] = digit_reg[gi];
        end
    endgenerate

    assign dig_valid = valid_reg;
    assign dig_err   = err_reg;
    assign upd_stb   = upd_stb_reg;
    assign upd_idx   = upd_idx_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=6, STABLE_CYC=4); one task per scenario.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [5:0]  dig_sel = '0;
    logic [6:0]  seg_in = 7'h7F;
    logic        dp_in = 1'b1;
    logic [23:0] digits;
    logic [5:0]  dig_valid;
    logic [5:0]  dig_err;
    logic        upd_stb;
    logic [2:0]  upd_idx;
`ifdef SEG7_SCAN_DECODER_DP_EN
    logic [5:0]  dig_dp;
`endif

    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    logic [2:0] last_idx = 3'd0;

    localparam logic [6:0] P_1 = 7'b1111001;
    localparam logic [6:0] P_3 = 7'b0110000;
    localparam logic [6:0] P_5 = 7'b0010010;
    localparam logic [6:0] P_7 = 7'b1111000;
    localparam logic [6:0] P_8 = 7'b0000000;
    localparam logic [6:0] P_A = 7'b0001000;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_BAD = 7'b0101010;

    seg7_scan_decoder #(.NDIG(6), .STABLE_CYC(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_en(sample_en),
        .dig_sel(dig_sel),
        .seg_in(seg_in),
`ifdef SEG7_SCAN_DECODER_DP_EN
        .dp_in(dp_in),
        .dig_dp(dig_dp),
`endif
        .digits(digits),
        .dig_valid(dig_valid),
        .dig_err(dig_err),
        .upd_stb(upd_stb),
        .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    // Drive one cycle of bus, then look at outputs 1ns after the edge and log any strobe.
    task automatic step(input logic en, input logic [5:0] sel, input logic [6:0] seg);
        sample_en = en;
        dig_sel   = sel;
        seg_in    = seg;
        @(posedge clk);
        #1;
        if (upd_stb === 1'b1) begin
            stb_count++;
            last_idx = upd_idx;
            $display("commit: idx=%0d digits=%h valid=%b err=%b", upd_idx, digits, dig_valid, dig_err);
        end
    endtask

    task automatic steps(input int n, input logic [5:0] sel, input logic [6:0] seg);
        for (int k = 0; k < n; k++) step(1'b1, sel, seg);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b1, 6'b000001, P_3);
        step(1'b0, 6'b000000, P_BLANK);
        checks++; if (digits !== 24'h0) begin errors++; $display("FAIL reset_digits: got %h expected %h", digits, 24'h0); end
        checks++; if (dig_valid !== 6'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", dig_valid, 6'b0); end
        checks++; if (dig_err !== 6'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", dig_err, 6'b0); end
        checks++; if (upd_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", upd_stb); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", upd_idx); end
        rst_n = 1'b1;
        stb_count = 0;
    endtask

    task automatic test_commit;
        steps(4, 6'b000001, P_3);
        checks++; if (stb_count != 0) begin errors++; $display("FAIL commit_early: got %0d strobes expected 0", stb_count); end
        step(1'b1, 6'b000001, P_3);
        checks++; if (upd_stb !== 1'b1) begin errors++; $display("FAIL commit_stb: got %b expected 1", upd_stb); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL commit_idx: got %0d expected 0", upd_idx); end
        checks++; if (digits[3:0] !== 4'h3) begin errors++; $display("FAIL commit_digit0: got %h expected 3", digits[3:0]); end
        checks++; if (dig_valid !== 6'b000001) begin errors++; $display("FAIL commit_valid: got %b expected 000001", dig_valid); end
        checks++; if (dig_err !== 6'b0) begin errors++; $display("FAIL commit_err: got %b expected 000000", dig_err); end
    endtask

    task automatic test_hold;
        int base;
        base = stb_count;
        steps(20, 6'b000001, P_3);
        step(1'b0, 6'b000001, P_3);
        checks++; if (stb_count != base) begin errors++; $display("FAIL hold_recommit: got %0d strobes expected %0d", stb_count, base); end
        checks++; if (digits !== 24'h000003) begin errors++; $display("FAIL hold_digits: got %h expected 000003", digits); end
        checks++; if (dig_valid !== 6'b000001) begin errors++; $display("FAIL hold_valid: got %b expected 000001", dig_valid); end
    endtask

    task automatic test_restart;
        int base;
        base = stb_count;
        steps(3, 6'b000100, P_A);
        steps(4, 6'b000100, P_1);
        step(1'b0, 6'b000100, P_1);
        checks++; if (stb_count != base + 1) begin errors++; $display("FAIL restart_count: got %0d strobes expected %0d", stb_count, base + 1); end
        checks++; if (last_idx !== 3'd2) begin errors++; $display("FAIL restart_idx: got %0d expected 2", last_idx); end
        checks++; if (digits[11:8] !== 4'h1) begin errors++; $display("FAIL restart_digit2: got %h expected 1", digits[11:8]); end
        checks++; if (dig_valid !== 6'b000101) begin errors++; $display("FAIL restart_valid: got %b expected 000101", dig_valid); end
    endtask

    task automatic test_unknown_blank;
        steps(4, 6'b000010, P_7);
        step(1'b0, 6'b000010, P_7);
        checks++; if (digits[7:4] !== 4'h7) begin errors++; $display("FAIL seven_digit1: got %h expected 7", digits[7:4]); end
        steps(4, 6'b000010, P_BAD);
        step(1'b0, 6'b000010, P_BAD);
        checks++; if (dig_err !== 6'b000010) begin errors++; $display("FAIL unknown_err: got %b expected 000010", dig_err); end
        checks++; if (dig_valid !== 6'b000101) begin errors++; $display("FAIL unknown_valid: got %b expected 000101", dig_valid); end
        checks++; if (digits[7:4] !== 4'h7) begin errors++; $display("FAIL unknown_keep: got %h expected 7", digits[7:4]); end
        steps(4, 6'b000010, P_BLANK);
        step(1'b0, 6'b000010, P_BLANK);
        checks++; if (dig_err !== 6'b0) begin errors++; $display("FAIL blank_err: got %b expected 000000", dig_err); end
        checks++; if (digits !== 24'h000103) begin errors++; $display("FAIL blank_digits: got %h expected 000103", digits); end
        checks++; if (dig_valid !== 6'b000101) begin errors++; $display("FAIL blank_valid: got %b expected 000101", dig_valid); end
    endtask

    task automatic test_bad_select;
        int base;
        base = stb_count;
        steps(3, 6'b001000, P_5);
        step(1'b1, 6'b000011, P_5);
        steps(3, 6'b001000, P_5);
        step(1'b0, 6'b001000, P_5);
        checks++; if (stb_count != base) begin errors++; $display("FAIL badsel_early: got %0d strobes expected %0d", stb_count, base); end
        step(1'b1, 6'b001000, P_5);
        step(1'b0, 6'b001000, P_5);
        checks++; if (stb_count != base + 1) begin errors++; $display("FAIL badsel_commit: got %0d strobes expected %0d", stb_count, base + 1); end
        checks++; if (last_idx !== 3'd3) begin errors++; $display("FAIL badsel_idx: got %0d expected 3", last_idx); end
        checks++; if (digits[15:12] !== 4'h5) begin errors++; $display("FAIL badsel_digit3: got %h expected 5", digits[15:12]); end
    endtask

    task automatic test_reset_mid;
        int base;
        steps(3, 6'b010000, P_8);
        rst_n = 1'b0;
        step(1'b1, 6'b010000, P_8);
        rst_n = 1'b1;
        base = stb_count;
        step(1'b0, 6'b010000, P_8);
        step(1'b0, 6'b010000, P_8);
        checks++; if (stb_count != base) begin errors++; $display("FAIL rstmid_stb: got %0d strobes expected %0d", stb_count, base); end
        checks++; if (digits !== 24'h0) begin errors++; $display("FAIL rstmid_digits: got %h expected 000000", digits); end
        checks++; if (dig_valid !== 6'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 000000", dig_valid); end
        checks++; if (dig_err !== 6'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 000000", dig_err); end
        dp_in = 1'b0;
        steps(4, 6'b010000, P_8);
        step(1'b0, 6'b010000, P_8);
        dp_in = 1'b1;
        checks++; if (digits !== 24'h080000) begin errors++; $display("FAIL after_rst_digits: got %h expected 080000", digits); end
        checks++; if (last_idx !== 3'd4) begin errors++; $display("FAIL after_rst_idx: got %0d expected 4", last_idx); end
`ifdef SEG7_SCAN_DECODER_DP_EN
        checks++; if (dig_dp !== 6'b010000) begin errors++; $display("FAIL dp_capture: got %b expected 010000", dig_dp); end
`endif
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hold();
        test_restart();
        test_unknown_blank();
        test_bad_select();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
